// File: rtl/mem_interface_multi_pkg.sv
// Shared encodings for the multicycle memory access unit: FSM states,
// load/store funct3 codes, access sizes and the reset instruction.
package mem_interface_multi_pkg;

    typedef enum logic [1:0] {
        MA_IDLE   = 2'd0,
        MA_ACCESS = 2'd1,
        MA_DONE   = 2'd2
    } ma_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } ma_size_e;

    // Identity of a command; a change of kind while in MA_DONE starts a new access.
    typedef struct packed {
        logic is_write;
        logic is_data;
    } ma_kind_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/mem_interface_multi_load_align.sv
// Load formatter: picks the addressed byte/half lane of a bus word and
// sign- or zero-extends it according to the load funct3.
module mem_load_align
    import mem_interface_multi_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            FUNCT3_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            FUNCT3_LBU: load_data = {24'd0, byte_sel};
            FUNCT3_LHU: load_data = {16'd0, half_sel};
            default:    load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_interface_multi.sv
// Memory access unit between the multicycle control FSM and the shared bus:
// turns level MemRead/MemWrite commands into single req/ack transactions.
module mem_interface_multi
    import mem_interface_multi_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iIouD,
    input  logic        iEscreveIR,
    input  logic [31:0] iPC,
    input  logic [31:0] iALUOut,
    input  logic [31:0] iStoreData,
    input  logic [2:0]  iFunct3,
    output logic [31:0] oIR,
    output logic [31:0] oMDR,
    output logic        oBusy,
    output logic        oMisalign,
    output logic        oBusErr,
    output logic        oBusReq,
    output logic        oBusWe,
    output logic [31:0] oBusAddr,
    output logic [31:0] oBusWData,
    output logic [3:0]  oBusBE,
    input  logic        iBusAck,
    input  logic [31:0] iBusRData,
    output logic [1:0]  oMaState
);

    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT[7:0];

    ma_state_e   state_q, state_d;
    ma_kind_t    kind_q, kind_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        eir_q, eir_d;
    logic        misalign_q, misalign_d;
    logic        buserr_q, buserr_d;

    logic        cmd;
    logic        launch;
    logic        misaligned;
    ma_kind_t    kind_new;
    ma_size_e    size;
    logic [31:0] sel_addr;
    logic [31:0] new_wdata;
    logic [3:0]  new_be;
    logic [31:0] load_data;

    mem_load_align u_load_align (
        .rdata     (iBusRData),
        .addr      (addr_q[1:0]),
        .funct3    (funct3_q),
        .load_data (load_data)
    );

    // Decode of the command currently presented by the control unit.
    always_comb begin
        cmd      = iMemRead | iMemWrite;
        kind_new = '{is_write: iMemWrite, is_data: iIouD};
        sel_addr = iIouD ? iALUOut : iPC;

        if (iMemWrite) begin
            case (iFunct3)
                FUNCT3_SB: size = SZ_BYTE;
                FUNCT3_SH: size = SZ_HALF;
                default:   size = SZ_WORD;
            endcase
        end else if (!iIouD) begin
            size = SZ_WORD;
        end else begin
            case (iFunct3)
                FUNCT3_LB, FUNCT3_LBU: size = SZ_BYTE;
                FUNCT3_LH, FUNCT3_LHU: size = SZ_HALF;
                default:               size = SZ_WORD;
            endcase
        end

        case (size)
            SZ_BYTE: begin
                new_be     = 4'b0001 << sel_addr[1:0];
                new_wdata  = {4{iStoreData[7:0]}};
                misaligned = 1'b0;
            end
            SZ_HALF: begin
                new_be     = sel_addr[1] ? 4'b1100 : 4'b0011;
                new_wdata  = {2{iStoreData[15:0]}};
                misaligned = sel_addr[0];
            end
            default: begin
                new_be     = 4'b1111;
                new_wdata  = iStoreData;
                misaligned = (sel_addr[1:0] != 2'b00);
            end
        endcase

        launch = cmd && ((state_q == MA_IDLE) ||
                         ((state_q == MA_DONE) && (kind_new != kind_q)));
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ir_d       = ir_q;
        mdr_d      = mdr_q;
        be_d       = be_q;
        funct3_d   = funct3_q;
        tcnt_d     = tcnt_q;
        req_d      = req_q;
        we_d       = we_q;
        eir_d      = eir_q;
        misalign_d = 1'b0;
        buserr_d   = 1'b0;

        case (state_q)
            MA_IDLE, MA_DONE: begin
                if (launch) begin
                    kind_d = kind_new;
                    if (misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = MA_DONE;
                    end else begin
                        addr_d   = sel_addr;
                        wdata_d  = new_wdata;
                        be_d     = new_be;
                        we_d     = iMemWrite;
                        funct3_d = iFunct3;
                        eir_d    = iEscreveIR;
                        tcnt_d   = 8'd0;
                        req_d    = 1'b1;
                        state_d  = MA_ACCESS;
                    end
                end else if (!cmd) begin
                    state_d = MA_IDLE;
                end
            end
            MA_ACCESS: begin
                // An ack in the timeout cycle still completes the access.
                if (iBusAck) begin
                    req_d   = 1'b0;
                    state_d = MA_DONE;
                    if (!kind_q.is_write) begin
                        if (kind_q.is_data) begin
                            mdr_d = load_data;
                        end else if (eir_q) begin
                            ir_d = iBusRData;
                        end
                    end
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                    if (tcnt_q + 8'd1 == TIMEOUT_LIM) begin
                        req_d    = 1'b0;
                        buserr_d = 1'b1;
                        state_d  = MA_DONE;
                    end
                end
            end
            default: state_d = MA_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= MA_IDLE;
            kind_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ir_q       <= NOP;
            mdr_q      <= '0;
            be_q       <= '0;
            funct3_q   <= '0;
            tcnt_q     <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            eir_q      <= 1'b0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ir_q       <= ir_d;
            mdr_q      <= mdr_d;
            be_q       <= be_d;
            funct3_q   <= funct3_d;
            tcnt_q     <= tcnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            eir_q      <= eir_d;
            misalign_q <= misalign_d;
            buserr_q   <= buserr_d;
        end
    end

    assign oIR       = ir_q;
    assign oMDR      = mdr_q;
    assign oBusy     = (state_q == MA_ACCESS) || launch;
    assign oMisalign = misalign_q;
    assign oBusErr   = buserr_q;
    assign oBusReq   = req_q;
    assign oBusWe    = we_q;
    assign oBusAddr  = {addr_q[31:2], 2'b00};
    assign oBusWData = wdata_q;
    assign oBusBE    = be_q;
    assign oMaState  = state_q;

endmodule

// File: tb/tb_mem_interface_multi.sv
// Directed bench for mem_interface_multi: the driver pushes each expected bus
// request into exp_q and a negedge monitor pops it when oBusReq rises.
module tb_mem_interface_multi;

    localparam int W = 69;

    logic        clk;
    logic        iRST;
    logic        iMemRead, iMemWrite, iIouD, iEscreveIR;
    logic [31:0] iPC, iALUOut, iStoreData;
    logic [2:0]  iFunct3;
    logic [31:0] oIR, oMDR;
    logic        oBusy, oMisalign, oBusErr, oBusReq, oBusWe;
    logic [31:0] oBusAddr, oBusWData;
    logic [3:0]  oBusBE;
    logic        iBusAck;
    logic [31:0] iBusRData;
    logic [1:0]  oMaState;

    mem_interface_multi #(.TIMEOUT(4)) dut (
        .iCLK(clk), .iRST(iRST),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iIouD(iIouD), .iEscreveIR(iEscreveIR),
        .iPC(iPC), .iALUOut(iALUOut), .iStoreData(iStoreData), .iFunct3(iFunct3),
        .oIR(oIR), .oMDR(oMDR), .oBusy(oBusy), .oMisalign(oMisalign), .oBusErr(oBusErr),
        .oBusReq(oBusReq), .oBusWe(oBusWe), .oBusAddr(oBusAddr), .oBusWData(oBusWData),
        .oBusBE(oBusBE), .iBusAck(iBusAck), .iBusRData(iBusRData), .oMaState(oMaState)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: {we, be, word address, wdata}
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int misalign_pulses = 0;
    int buserr_pulses = 0;
    logic req_prev = 1'b0;
    logic [W-1:0] mon_exp, mon_got;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wd);
        exp_q.push_back({we, be, addr & 32'hFFFF_FFFC, wd});
    endtask

    // Monitor
    always @(negedge clk) begin
        if (oBusReq === 1'b1 && !req_prev) begin
            checks++;
            mon_got = {oBusWe, oBusBE, oBusAddr, oBusWData};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req got=%h exp=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (!mon_exp[W-1]) begin
                    mon_exp[31:0] = '0;
                    mon_got[31:0] = '0;
                end
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL bus_req got=%h exp=%h", mon_got, mon_exp);
                end
            end
        end
        req_prev = (oBusReq === 1'b1);
        if (oMisalign === 1'b1) misalign_pulses++;
        if (oBusErr === 1'b1) buserr_pulses++;
    end

    // Driver tasks
    task automatic set_cmd(input logic rd, input logic wr, input logic iou, input logic eir,
                           input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] f3);
        iMemRead   = rd;
        iMemWrite  = wr;
        iIouD      = iou;
        iEscreveIR = eir;
        if (iou) iALUOut = addr;
        else     iPC = addr;
        iStoreData = sd;
        iFunct3    = f3;
    endtask

    task automatic clr_cmd();
        iMemRead  = 1'b0;
        iMemWrite = 1'b0;
    endtask

    // Acks on the (waits+1)-th request cycle; returns request and busy cycle counts.
    task automatic do_access(input logic rd, input logic wr, input logic iou, input logic eir,
                             input logic [31:0] addr, input logic [31:0] sd, input logic [2:0] f3,
                             input int waits, input logic [31:0] rdata, input int hold,
                             input logic drop, output int reqc, output int busyc);
        logic done;
        set_cmd(rd, wr, iou, eir, addr, sd, f3);
        @(negedge clk);
        check("busy_launch", {31'd0, oBusy}, 32'd1);
        @(posedge clk); #1;
        reqc = 0;
        busyc = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (oBusReq !== 1'b1) begin
                done = 1'b1;
            end else begin
                reqc++;
                if (oBusy === 1'b1) busyc++;
                if (reqc == waits + 1) begin
                    iBusAck   = 1'b1;
                    iBusRData = rdata;
                end
                @(posedge clk); #1;
                iBusAck = 1'b0;
                if (reqc == waits + 1) done = 1'b1;
            end
        end
        if (reqc == waits + 1) begin
            check("busy_after_ack", {31'd0, oBusy}, 32'd0);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check("done_hold_state", {30'd0, oMaState}, 32'd2);
            end
        end
        if (drop) begin
            clr_cmd();
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] ld_addr [4];
    logic [31:0] ld_data [4];
    logic [2:0]  ld_f3   [4];
    logic [3:0]  ld_be   [4];
    logic [31:0] ld_exp  [4];
    logic [31:0] exp_mdr;
    int reqc, busyc;

    initial begin
        ld_addr = '{32'h101, 32'h102, 32'h102, 32'h104};
        ld_data = '{32'h12348756, 32'hBEEF1234, 32'hBEEF1234, 32'hCAFEF00D};
        ld_f3   = '{3'b100, 3'b101, 3'b001, 3'b010};
        ld_be   = '{4'b0010, 4'b1100, 4'b1100, 4'b1111};
        ld_exp  = '{32'h00000087, 32'h0000BEEF, 32'hFFFFBEEF, 32'hCAFEF00D};

        iRST = 1'b1;
        iMemRead = 0; iMemWrite = 0; iIouD = 0; iEscreveIR = 0;
        iPC = 0; iALUOut = 0; iStoreData = 0; iFunct3 = 0;
        iBusAck = 0; iBusRData = 0;
        repeat (3) @(posedge clk);
        #1 iRST = 1'b0;
        @(negedge clk);
        check("rst_ir", oIR, 32'h00000013);
        check("rst_mdr", oMDR, 32'd0);
        check("rst_req", {31'd0, oBusReq}, 32'd0);
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        check("rst_state", {30'd0, oMaState}, 32'd0);
        check("rst_addr", oBusAddr, 32'd0);
        check("rst_wdata", oBusWData, 32'd0);
        check("rst_be_we", {27'd0, oBusWe, oBusBE}, 32'd0);
        check("rst_pulses", {30'd0, oMisalign, oBusErr}, 32'd0);

        // Fetch, zero wait, command held two cycles
        push_exp(1'b0, 4'b1111, 32'h40, 32'd0);
        do_access(1, 0, 0, 1, 32'h40, 32'd0, 3'b111, 0, 32'h00500093, 0, 1, reqc, busyc);
        check("fetch_reqc", reqc, 32'd1);
        check("fetch_ir", oIR, 32'h00500093);

        // LB with 3 wait states; the ack lands on the timeout cycle and must win
        push_exp(1'b0, 4'b1000, 32'h103, 32'd0);
        do_access(1, 0, 1, 0, 32'h103, 32'd0, 3'b000, 3, 32'h80FFFFFF, 1, 1, reqc, busyc);
        check("lb_reqc", reqc, 32'd4);
        check("lb_busyc", busyc, 32'd4);
        check("lb_mdr", oMDR, 32'hFFFFFF80);
        check("lb_no_buserr", buserr_pulses, 32'd0);

        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, ld_be[i], ld_addr[i], 32'd0);
            do_access(1, 0, 1, 0, ld_addr[i], 32'd0, ld_f3[i], i, ld_data[i], 0, 1, reqc, busyc);
            check("ld_mdr", oMDR, ld_exp[i]);
        end
        exp_mdr = 32'hCAFEF00D;

        // Stores: SH, SB, then SW followed back-to-back by a fetch
        push_exp(1'b1, 4'b1100, 32'h22, 32'hBEEFBEEF);
        do_access(0, 1, 1, 0, 32'h22, 32'h0000BEEF, 3'b001, 1, 32'd0, 0, 1, reqc, busyc);
        check("sh_mdr_kept", oMDR, exp_mdr);
        push_exp(1'b1, 4'b1000, 32'h23, 32'hA5A5A5A5);
        do_access(1, 1, 1, 0, 32'h23, 32'h123456A5, 3'b000, 0, 32'd0, 0, 1, reqc, busyc);
        push_exp(1'b1, 4'b1111, 32'h30, 32'h11223344);
        do_access(0, 1, 1, 0, 32'h30, 32'h11223344, 3'b010, 1, 32'd0, 0, 0, reqc, busyc);
        push_exp(1'b0, 4'b1111, 32'h44, 32'd0);
        do_access(1, 0, 0, 1, 32'h44, 32'd0, 3'b010, 0, 32'h00A00113, 1, 1, reqc, busyc);
        check("sw_fetch_ir", oIR, 32'h00A00113);

        // Misaligned LW: pulse only, no bus cycle
        set_cmd(1, 0, 1, 0, 32'h102, 32'd0, 3'b010);
        @(posedge clk); #1;
        check("mis_pulse", {31'd0, oMisalign}, 32'd1);
        check("mis_no_req", {31'd0, oBusReq}, 32'd0);
        check("mis_state", {30'd0, oMaState}, 32'd2);
        @(posedge clk); #1;
        check("mis_pulse_end", {31'd0, oMisalign}, 32'd0);
        clr_cmd();
        @(posedge clk); #1;
        check("mis_mdr_kept", oMDR, exp_mdr);

        // Timeout: never ack
        push_exp(1'b0, 4'b1111, 32'h200, 32'd0);
        do_access(1, 0, 1, 0, 32'h200, 32'd0, 3'b010, 1000, 32'd0, 0, 0, reqc, busyc);
        check("to_reqc", reqc, 32'd4);
        check("to_buserr", {31'd0, oBusErr}, 32'd1);
        check("to_state", {30'd0, oMaState}, 32'd2);
        clr_cmd();
        @(posedge clk); #1;
        check("to_buserr_end", {31'd0, oBusErr}, 32'd0);
        check("to_mdr_kept", oMDR, exp_mdr);
        push_exp(1'b0, 4'b1111, 32'h48, 32'd0);
        do_access(1, 0, 0, 1, 32'h48, 32'd0, 3'b000, 2, 32'h00208033, 0, 1, reqc, busyc);
        check("to_fetch_ir", oIR, 32'h00208033);

        // Reset during an access, then a late ack in idle
        push_exp(1'b0, 4'b1111, 32'h80, 32'd0);
        set_cmd(1, 0, 0, 1, 32'h80, 32'd0, 3'b010);
        @(posedge clk); #1;
        check("rstmid_req", {31'd0, oBusReq}, 32'd1);
        iRST = 1'b1;
        @(posedge clk); #1;
        check("rstmid_req_low", {31'd0, oBusReq}, 32'd0);
        check("rstmid_ir", oIR, 32'h00000013);
        iRST = 1'b0;
        clr_cmd();
        iBusAck = 1'b1;
        iBusRData = 32'hDEADBEEF;
        @(posedge clk); #1;
        iBusAck = 1'b0;
        check("late_ack_ir", oIR, 32'h00000013);
        check("late_ack_mdr", oMDR, 32'd0);
        check("late_ack_state", {30'd0, oMaState}, 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("misalign_pulses", misalign_pulses, 32'd1);
        check("buserr_pulses", buserr_pulses, 32'd1);
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
